// File: rtl/adc_serial_rx.sv
// Delta-sigma ADC serial receiver: generates adc_sclk, shifts in 24-bit MSB-first frames.
// Build option ADC_OFFSET_EN adds a registered, saturating offset subtraction on the output.
module adc_serial_rx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_drdy_n,
  input  logic        adc_dout,
  input  logic [23:0] offset,
  output logic        adc_sclk,
  output logic [23:0] data_out,
  output logic        valid_out,
  output logic        overrun
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] PH_HALF    = PW'(CLK_DIV);
  localparam logic [PW-1:0] PH_HI_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_LAST    = PW'(2 * CLK_DIV - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state_q, state_d;
  logic          drdy_s1_q, drdy_s2_q, drdy_prev_q;
  logic          dout_s1_q, dout_s2_q;
  logic [PW-1:0] phase_q, phase_d;
  logic [4:0]    bit_q, bit_d;
  logic [23:0]   shift_q, shift_d;
  logic          sclk_q, sclk_d;
  logic          ovr_q, ovr_d;
  logic [23:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          drdy_fall;
  logic          frame_end;
  logic          smp_last;

  // Two-flop synchronisers on the asynchronous ADC lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drdy_s1_q   <= 1'b0;
      drdy_s2_q   <= 1'b0;
      drdy_prev_q <= 1'b0;
      dout_s1_q   <= 1'b0;
      dout_s2_q   <= 1'b0;
    end else begin
      drdy_s1_q   <= adc_drdy_n;
      drdy_s2_q   <= drdy_s1_q;
      drdy_prev_q <= drdy_s2_q;
      dout_s1_q   <= adc_dout;
      dout_s2_q   <= dout_s1_q;
    end
  end

  assign drdy_fall = drdy_prev_q & ~drdy_s2_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    ovr_d     = 1'b0;
    frame_end = 1'b0;
    smp_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (drdy_fall) begin
          state_d = SHIFT;
          bit_d   = 5'd23;
          phase_d = '0;
        end
      end
      SHIFT: begin
        if (phase_q == PH_HI_LAST) begin
          shift_d[bit_q] = dout_s2_q;
          smp_last       = (bit_q == 5'd0);
        end
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (bit_q == 5'd0) begin
            frame_end = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_d = bit_q - 5'd1;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
        // A new frame may start on the very cycle the old one finishes
        if (drdy_fall) begin
          if (frame_end) begin
            state_d = SHIFT;
            bit_d   = 5'd23;
            phase_d = '0;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    sclk_d = (state_d == SHIFT) && (phase_d < PH_HALF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef ADC_OFFSET_EN
  function automatic logic [23:0] sat24(input logic signed [24:0] v);
    if (v[24] != v[23]) return v[24] ? 24'h800000 : 24'h7FFFFF;
    return v[23:0];
  endfunction

  logic signed [23:0] raw_p0_q, raw_p0_d;
  logic signed [23:0] off_p0_q, off_p0_d;
  logic               vld_p0_q;
  logic signed [24:0] diff_p1;

  // Stage p0: capture sample and offset together; stage p1: subtract and clamp
  always_comb begin
    raw_p0_d = smp_last ? shift_d : raw_p0_q;
    off_p0_d = smp_last ? offset : off_p0_q;
    diff_p1  = $signed({raw_p0_q[23], raw_p0_q}) - $signed({off_p0_q[23], off_p0_q});
    data_d   = vld_p0_q ? sat24(diff_p1) : data_q;
    valid_d  = vld_p0_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_p0_q <= '0;
      off_p0_q <= '0;
      vld_p0_q <= 1'b0;
    end else begin
      raw_p0_q <= raw_p0_d;
      off_p0_q <= off_p0_d;
      vld_p0_q <= smp_last;
    end
  end
`else
  logic offset_unused;
  assign offset_unused = ^offset;

  always_comb begin
    data_d  = smp_last ? shift_d : data_q;
    valid_d = smp_last;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign adc_sclk  = sclk_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign overrun   = ovr_q;

endmodule
